dqs_wr_sequencer: RTL and testbench

//  Sequences the write-strobe (DQS) differential DDR output pair of the DDR3 PHY.
//  - Generates the 2-bit per-clock pattern {falling,rising} for the ODDR+OBUFDS(T) DQS wrapper.
//  - Generates the tristate control: preamble, toggling burst, postamble.
//  - Sits between the write command scheduler (start/ready handshake) and the DQS output wrapper.

---
 rtl/ddr_phy_seq_pkg.sv | 23 ++
 rtl/dqs_wr_sequencer.sv | 157 +++++++++++++++
 tb/tb_dqs_wr_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ddr_phy_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : ddr_phy_seq_pkg                                        |
// | Brief   : Shared state encodings and DQS pattern constants for   |
// |           the DDR3 PHY write-path sequencers.                    |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package ddr_phy_seq_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_PRE   = 3'd1;
  localparam logic [ST_W-1:0] ST_BURST = 3'd2;
  localparam logic [ST_W-1:0] ST_POST  = 3'd3;
  localparam logic [ST_W-1:0] ST_TRAIN = 3'd4;

  // {falling, rising} pair handed to the DQS ODDR wrapper
  localparam logic [1:0] DQS_PAT_IDLE   = 2'b00;
  localparam logic [1:0] DQS_PAT_TOGGLE = 2'b01;

endpackage : ddr_phy_seq_pkg
`default_nettype wire

// File: rtl/dqs_wr_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : dqs_wr_sequencer                                       |
// | Brief   : DQS write-strobe sequencer: preamble, toggling burst   |
// |           (seamlessly chainable), postamble, and tristate ctrl.  |
// |           Optional macro DQS_TRAIN_EN adds the wlev_en port and  |
// |           a write-leveling TRAIN state emitting periodic pulses. |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module dqs_wr_sequencer
  import ddr_phy_seq_pkg::*;
#(
  parameter int PREAMBLE_CYC  = 1,
  parameter int BURST_CYC     = 4,
  parameter int POSTAMBLE_CYC = 1,
  parameter int CNT_W         = 4,
  parameter int WLEV_PERIOD   = 8
) (
`ifdef DQS_TRAIN_EN
  input  logic       wlev_en,
`endif
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic [1:0] dqs_din,
  output logic       dqs_tri
);

  localparam logic [CNT_W-1:0] C_PRE_LOAD   = CNT_W'(PREAMBLE_CYC - 1);
  localparam logic [CNT_W-1:0] C_BURST_LOAD = CNT_W'(BURST_CYC - 1);
  localparam logic [CNT_W-1:0] C_POST_LOAD  = CNT_W'(POSTAMBLE_CYC - 1);
`ifdef DQS_TRAIN_EN
  localparam logic [CNT_W-1:0] C_WLEV_LAST  = CNT_W'(WLEV_PERIOD - 1);
`endif

  // Reject configurations the counter or protocol cannot honour
  if (PREAMBLE_CYC < 1 || BURST_CYC < 1 || POSTAMBLE_CYC < 1 || WLEV_PERIOD < 2)
  begin : g_param_check
    $error("dqs_wr_sequencer: illegal phase length parameter");
  end

  logic [ST_W-1:0]  r_state;
  logic [ST_W-1:0]  w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic [1:0]       w_next_dqs_din;
  logic             w_next_dqs_tri;
  logic             w_next_done;
  logic             w_next_busy;
  logic             w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  // Request window: idle, or the last beat of a burst for seamless chaining
  assign ready = (r_state == ST_IDLE) || ((r_state == ST_BURST) && w_cnt_zero);

  // State, phase counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      dqs_din <= DQS_PAT_IDLE;
      dqs_tri <= 1'b1;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      dqs_din <= w_next_dqs_din;
      dqs_tri <= w_next_dqs_tri;
      done    <= w_next_done;
      busy    <= w_next_busy;
    end
  end

  // Next-state and counter: loads are (length-1), decrements stop at zero
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
`ifdef DQS_TRAIN_EN
        if (wlev_en) begin
          w_next_state = ST_TRAIN;
          w_next_cnt   = '0;
        end else
`endif
        if (start) begin
          w_next_state = ST_PRE;
          w_next_cnt   = C_PRE_LOAD;
        end
      end
      ST_PRE: begin
        if (w_cnt_zero) begin
          w_next_state = ST_BURST;
          w_next_cnt   = C_BURST_LOAD;
        end else begin
          w_next_cnt = r_cnt - 1'b1;
        end
      end
      ST_BURST: begin
        if (!w_cnt_zero) begin
          w_next_cnt = r_cnt - 1'b1;
        end else if (start) begin
          w_next_cnt = C_BURST_LOAD;
        end else begin
          w_next_state = ST_POST;
          w_next_cnt   = C_POST_LOAD;
        end
      end
      ST_POST: begin
        if (w_cnt_zero) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_cnt = r_cnt - 1'b1;
        end
      end
`ifdef DQS_TRAIN_EN
      ST_TRAIN: begin
        if (!wlev_en) begin
          w_next_state = ST_POST;
          w_next_cnt   = C_POST_LOAD;
        end else if (r_cnt == C_WLEV_LAST) begin
          w_next_cnt = '0;
        end else begin
          w_next_cnt = r_cnt + 1'b1;
        end
      end
`endif
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  // Output decode of the upcoming state so outputs line up with it once registered
  always_comb begin
    w_next_dqs_din = DQS_PAT_IDLE;
    w_next_dqs_tri = (w_next_state == ST_IDLE);
    w_next_done    = (w_next_state == ST_POST) && (w_next_cnt == '0);
    w_next_busy    = (w_next_state != ST_IDLE);
    if (w_next_state == ST_BURST) begin
      w_next_dqs_din = DQS_PAT_TOGGLE;
    end
`ifdef DQS_TRAIN_EN
    if ((w_next_state == ST_TRAIN) && (w_next_cnt == '0)) begin
      w_next_dqs_din = DQS_PAT_TOGGLE;
    end
`endif
  end

endmodule : dqs_wr_sequencer
`default_nettype wire

// File: tb/tb_dqs_wr_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_dqs_wr_sequencer                                    |
// | Brief   : Self-checking bench for dqs_wr_sequencer: directed     |
// |           scenarios then random start/rst traffic, compared to   |
// |           an expected-waveform queue model. DQS_TRAIN_EN adds    |
// |           write-leveling scenarios.                              |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_dqs_wr_sequencer;

  localparam int P = 1;
  localparam int B = 4;
  localparam int Q = 1;
  localparam int W = 8;
`ifdef DQS_TRAIN_EN
  localparam bit TRAIN_ON = 1'b1;
`else
  localparam bit TRAIN_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       wlev = 1'b0;
  logic       ready, busy, done, dqs_tri;
  logic [1:0] dqs_din;

  dqs_wr_sequencer #(
    .PREAMBLE_CYC (P),
    .BURST_CYC    (B),
    .POSTAMBLE_CYC(Q),
    .CNT_W        (4),
    .WLEV_PERIOD  (W)
  ) dut (
`ifdef DQS_TRAIN_EN
    .wlev_en (wlev),
`endif
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .dqs_din (dqs_din),
    .dqs_tri (dqs_tri)
  );

  always #5 clk = ~clk;

  // Model: queue of expected per-cycle outputs for the remaining transaction
  typedef struct {
    logic [1:0] din;
    bit         dn;
    bit         last;
  } ent_t;

  ent_t q[$];
  bit   known = 1'b0;
  bit   training = 1'b0;
  int   tk = 0;
  int   total = 0;
  int   passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_bursts();
    for (int i = 0; i < B; i++) q.push_back('{2'b01, 1'b0, (i == B - 1)});
  endtask

  task automatic push_post();
    for (int i = 0; i < Q; i++) q.push_back('{2'b00, (i == Q - 1), 1'b0});
  endtask

  task automatic model_edge(input bit s, input bit r, input bit w);
    bit acc;
    if (r) begin
      q.delete();
      training = 1'b0;
      tk = 0;
      known = 1'b1;
    end else if (known) begin
      if (training) begin
        if (w) tk = (tk + 1) % W;
        else begin
          training = 1'b0;
          push_post();
        end
      end else if (q.size() == 0) begin
        if (TRAIN_ON && w) begin
          training = 1'b1;
          tk = 0;
        end else if (s) begin
          for (int i = 0; i < P; i++) q.push_back('{2'b00, 1'b0, 1'b0});
          push_bursts();
          push_post();
        end
      end else begin
        acc = s && q[0].last;
        void'(q.pop_front());
        if (acc) begin
          q.delete();
          push_bursts();
          push_post();
        end
      end
    end
  endtask

  // One clock: check ready for the current state, clock the inputs in, check outputs
  task automatic step(input bit s, input bit r, input bit w);
    start = s;
    rst   = r;
    wlev  = w;
    if (known) chk("ready", 32'(ready), 32'(!training && (q.size() == 0 || q[0].last)));
    @(posedge clk);
    #1;
    model_edge(s, r, w);
    if (training) begin
      chk("tri", 32'(dqs_tri), 32'd0);
      chk("din", 32'(dqs_din), (tk == 0) ? 32'd1 : 32'd0);
      chk("done", 32'(done), 32'd0);
      chk("busy", 32'(busy), 32'd1);
    end else if (q.size() == 0) begin
      chk("tri", 32'(dqs_tri), 32'd1);
      chk("din", 32'(dqs_din), 32'd0);
      chk("done", 32'(done), 32'd0);
      chk("busy", 32'(busy), 32'd0);
    end else begin
      chk("tri", 32'(dqs_tri), 32'd0);
      chk("din", 32'(dqs_din), 32'(q[0].din));
      chk("done", 32'(done), 32'(q[0].dn));
      chk("busy", 32'(busy), 32'd1);
    end
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1;
    // Reset held three cycles, then quiet idle
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    idle_n(2);
    chk("reset_ready", 32'(ready), 32'd1);

    // Single burst
    step(1'b1, 1'b0, 1'b0);
    idle_n(7);

    // Held start chains bursts; dropped after six cycles
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
    idle_n(8);

    // start during PRE and during POST is ignored
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle_n(4);
    step(1'b1, 1'b0, 1'b0);
    idle_n(3);

    // Reset mid-burst, start together with reset, then a normal burst
    step(1'b1, 1'b0, 1'b0);
    idle_n(2);
    step(1'b0, 1'b1, 1'b0);
    chk("rst_mid_done", 32'(done), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle_n(8);

    if (TRAIN_ON) begin
      // Write leveling for 20 cycles with a start attempt inside
      for (int i = 0; i < 20; i++) step(i == 5, 1'b0, 1'b1);
      idle_n(4);
      // wlev_en beats start in IDLE
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      idle_n(4);
    end

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 2) != 0),
           ($urandom_range(0, 49) == 0),
           TRAIN_ON && ($urandom_range(0, 9) < 2));
    end
    idle_n(6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_dqs_wr_sequencer
`default_nettype wire
